// File: rtl/radix4_booth_pkg.sv
// rtl/radix4_booth_pkg.sv - shared width default and Booth digit encoding for the radix-4 multiplier
package radix4_booth_pkg;

  // Operand width used when an instantiation does not override WIDTH.
  localparam int DEFAULT_WIDTH = 32;

  // Selected multiple of the multiplicand for one radix-4 Booth digit.
  typedef enum logic [2:0] {
    DIGIT_ZERO = 3'd0,
    DIGIT_POS1 = 3'd1,
    DIGIT_POS2 = 3'd2,
    DIGIT_NEG2 = 3'd3,
    DIGIT_NEG1 = 3'd4
  } booth_digit_e;

  // Triplet {b[2i+1], b[2i], b[2i-1]} to digit; 000 and 111 both mean zero.
  function automatic booth_digit_e booth_decode(input logic [2:0] triplet);
    booth_digit_e digit;
    digit = DIGIT_ZERO;
    case (triplet)
      3'b001, 3'b010: digit = DIGIT_POS1;
      3'b011:         digit = DIGIT_POS2;
      3'b100:         digit = DIGIT_NEG2;
      3'b101, 3'b110: digit = DIGIT_NEG1;
      default:        digit = DIGIT_ZERO;
    endcase
    return digit;
  endfunction

endpackage

// File: rtl/radix4_booth_comb.sv
// rtl/radix4_booth_comb.sv - combinational signed radix-4 Booth multiplier
module radix4_booth_comb
  import radix4_booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product
);

  localparam int DIGITS = WIDTH / 2;

  // Multiplicand sign-extended to the product width, and its doubled form.
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] a_dbl;
  // Multiplier with the implicit b[-1] = 0 appended below bit 0.
  logic [WIDTH:0]     b_ext;
  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] acc;

  assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
  assign a_dbl = {a_ext[2*WIDTH-2:0], 1'b0};
  assign b_ext = {b, 1'b0};

  // Select each partial product from its Booth digit and accumulate it at weight 4^i.
  always_comb begin
    acc     = '0;
    partial = '0;
    for (int i = 0; i < DIGITS; i++) begin
      case (booth_decode(b_ext[2*i +: 3]))
        DIGIT_POS1: partial = a_ext;
        DIGIT_POS2: partial = a_dbl;
        DIGIT_NEG2: partial = -a_dbl;
        DIGIT_NEG1: partial = -a_ext;
        default:    partial = '0;
      endcase
      acc = acc + (partial << (2 * i));
    end
  end

  assign product = acc;

endmodule

// File: rtl/radix4_booth_with_regs.sv
// rtl/radix4_booth_with_regs.sv - two-stage registered signed radix-4 Booth multiplier
module radix4_booth_with_regs
  import radix4_booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]          a,
  input  logic [WIDTH-1:0]          b,
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  output logic signed [2*WIDTH-1:0] result
);

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] product;

  // Operand capture stage; reset wins over enable so in-flight operands are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else if (en) begin
      a_q <= a;
      b_q <= b;
    end
  end

  radix4_booth_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .a      (a_q),
    .b      (b_q),
    .product(product)
  );

  // Product stage; the output is driven only from this register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
    end else if (en) begin
      result <= product;
    end
  end

endmodule

// File: tb/tb_radix4_booth_with_regs.sv
// tb/tb_radix4_booth_with_regs.sv - scoreboard bench for the registered radix-4 Booth multiplier
module tb_radix4_booth_with_regs;

  localparam int W = 32;

  logic                  clk;
  logic                  reset;
  logic                  en;
  logic signed [W-1:0]   a;
  logic signed [W-1:0]   b;
  logic signed [2*W-1:0] result;

  int checks;
  int errors;
  int cyc;

  typedef struct {
    longint exp;
    int     due;
    string  tag;
  } sb_t;

  sb_t sb_q[$];

  radix4_booth_with_regs #(
    .WIDTH(W)
  ) dut (
    .a     (a),
    .b     (b),
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Apply one operand pair right after a clock edge and expect its product two edges later.
  task automatic drive(input string tag, input logic signed [W-1:0] x, input logic signed [W-1:0] y);
    sb_t item;
    @(posedge clk);
    #1;
    a = x;
    b = y;
    item.exp = longint'(x) * longint'(y);
    item.due = cyc + 2;
    item.tag = tag;
    sb_q.push_back(item);
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while (sb_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #3;
    if (sb_q.size() > 0) begin
      check("drain_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
  endtask

  // Compare due scoreboard entries against the registered result, away from the edge.
  always @(posedge clk) begin
    #2;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      sb_t item;
      item = sb_q.pop_front();
      check(item.tag, result, item.exp);
    end
  end

  initial begin
    logic signed [W-1:0] da [8];
    logic signed [W-1:0] db [8];
    checks = 0;
    errors = 0;
    cyc    = 0;
    reset  = 1'b1;
    en     = 1'b1;
    a      = 32'sd5;
    b      = 32'sd7;

    // Reset held with enable high keeps the result at zero.
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_hold", result, 64'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed pairs, each held for two cycles.
    da = '{32'sd5, 32'sd2, -32'sd12, -32'sd9, 32'sd11, 32'sd10, 32'sd4, -32'sd1};
    db = '{-32'sd7, 32'sd3, -32'sd4, 32'sd5, 32'sd0, 32'sd1, 32'sd6, -32'sd7};
    for (int i = 0; i < 8; i++) begin
      drive($sformatf("dir%0d", i), da[i], db[i]);
      drive($sformatf("dir%0d_hold", i), da[i], db[i]);
    end
    drain();
    check("dir_const_a", result, 64'sd7);

    // Extremes of the signed range.
    drive("min_x_min", 32'sh8000_0000, 32'sh8000_0000);
    drive("max_x_max", 32'sh7fff_ffff, 32'sh7fff_ffff);
    drive("min_x_one", 32'sh8000_0000, 32'sd1);
    drive("min_x_m1", 32'sh8000_0000, -32'sd1);
    drain();
    check("min_x_m1_const", result, 64'sh0000_0000_8000_0000);

    // Enable hold: result freezes while en is low and resumes with a two-edge latency.
    drive("en_pre", 32'sd3, 32'sd4);
    drain();
    en = 1'b0;
    a  = 32'sd7;
    b  = 32'sd7;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("en_hold", result, 64'sd12);
    end
    en = 1'b1;
    @(posedge clk);
    #1;
    check("en_resume1", result, 64'sd12);
    @(posedge clk);
    #1;
    check("en_resume2", result, 64'sd49);

    // Asynchronous reset between edges clears the result at once and drops in-flight work.
    drive("pre_rst0", 32'sd100, 32'sd3);
    drive("pre_rst1", 32'sd9, 32'sd9);
    drain();
    @(posedge clk);
    #5;
    reset = 1'b1;
    sb_q.delete();
    #1;
    check("async_clear", result, 64'd0);
    @(posedge clk);
    #1;
    check("rst_edge", result, 64'd0);
    a = 32'sd6;
    b = -32'sd8;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_edge1", result, 64'd0);
    @(posedge clk);
    #1;
    check("post_rst_edge2", result, -64'sd48);

    // Back-to-back random pairs, one per cycle.
    for (int i = 0; i < 10000; i++) begin
      logic signed [W-1:0] rx;
      logic signed [W-1:0] ry;
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 15))
        0: rx = 32'sh8000_0000;
        1: ry = 32'sh7fff_ffff;
        2: ry = -32'sd1;
        default: ;
      endcase
      drive("rand", rx, ry);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/radix4_booth_with_regs.md
RADIX4_BOOTH_WITH_REGS -- requirements
Module: radix4_booth_with_regs

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand width in bits; the result width is 2*WIDTH; WIDTH SHALL be even.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port a, input, WIDTH bits: multiplicand, two's-complement signed.
REQ-005 SHALL have port b, input, WIDTH bits: multiplier, two's-complement signed.
REQ-006 SHALL have port en, input, 1 bit: register enable for all pipeline registers.
REQ-007 SHALL have port result, output, 2*WIDTH bits, signed: registered product a*b.
REQ-008 SHALL keep positional port order a, b, clk, reset, en, result for existing instantiations.

Function
REQ-009 SHALL capture a and b into input registers a_q and b_q on each rising clk edge while en=1; they hold while en=0.
REQ-010 SHALL compute the full signed product a_q*b_q combinationally with a radix-4 Booth multiplier.
REQ-011 SHALL form WIDTH/2 Booth digits from triplets {b_q[2i+1], b_q[2i], b_q[2i-1]}, with b_q[-1]=0.
REQ-012 SHALL map triplets 000/111->0, 001/010->+A, 011->+2A, 100->-2A, 101/110->-A, where A is a_q sign-extended to 2*WIDTH bits.
REQ-013 SHALL shift partial product i left by 2i bits and sum all partial products modulo 2^(2*WIDTH).
REQ-014 SHALL register the product into result on each rising clk edge while en=1; result holds while en=0.
REQ-015 SHALL have a latency of 2 rising edges from input change to result, with en=1 throughout; throughput is one product per cycle.
REQ-016 SHALL produce the exact result for every operand pair, including -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2), with no overflow possible.
REQ-017 SHALL drive result from a register only, with no combinational path from a or b to result.

Reset
REQ-018 SHALL asynchronously clear a_q, b_q and result to 0 while reset=1, regardless of clk and en.
REQ-019 SHALL take priority over en when reset and a clock edge coincide, with all registers staying 0.
REQ-020 SHALL, when reset is asserted mid-operation, discard in-flight products; the first valid result appears 2 enabled edges after reset deasserts.

Structure
REQ-021 SHALL place the default width constant (32) and the Booth digit encoding constants in a shared package, radix4_booth_pkg.
REQ-022 SHALL implement the combinational multiplier as one sub-module, radix4_booth_comb (inputs a, b; output product), instantiated between the input and output registers.
REQ-023 SHALL keep the implementation within 120-400 lines of RTL in total.

Verification
REQ-024 SHALL check that with reset=1 and en=1, result=0; also assert reset asynchronously between edges and check that result clears immediately.
REQ-025 SHALL apply, with en=1 and inputs held 2 cycles each, these pairs and check result after 2 edges: (5,-7)->-35, (2,3)->6, (-12,-4)->48, (-9,5)->-45, (11,0)->0, (10,1)->10, (4,6)->24, (-1,-7)->7.
REQ-026 SHALL check the extremes: (-2^31,-2^31)->2^62, (2^31-1,2^31-1)->2^62-2^32+1, and (-2^31,1)->-2^31.
REQ-027 SHALL check enable hold: compute (3,4)->12, then set en=0 and change inputs to (7,7); result stays 12 for 3 cycles, then becomes 49 two edges after en=1.
REQ-028 SHALL check back-to-back pipelining: new pairs every cycle produce the matching products every cycle, each 2 edges later.
REQ-029 SHALL run at least 10000 random signed operand pairs against a reference a*b model with 2-cycle alignment and zero mismatches.
